// File: rtl/updown_count_monitor_pkg.sv
// Shared constants for the up/down counter and its monitor: FSM encodings and
// the active-high seven-segment pattern table.
package updown_count_monitor_pkg;

   localparam int unsigned CNT_W_DEFAULT = 3;
   localparam int unsigned SEG_W         = 7;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_TRACK = 2'd1,
      ST_ERROR = 2'd2
   } mon_state_t;

   // Segment order {g,f,e,d,c,b,a}, 1 = segment lit
   function automatic logic [SEG_W-1:0] seg7_pattern(input logic [3:0] nib);
      logic [SEG_W-1:0] p;
      case (nib)
         4'h0:    p = 7'h3F;
         4'h1:    p = 7'h06;
         4'h2:    p = 7'h5B;
         4'h3:    p = 7'h4F;
         4'h4:    p = 7'h66;
         4'h5:    p = 7'h6D;
         4'h6:    p = 7'h7D;
         4'h7:    p = 7'h07;
         4'h8:    p = 7'h7F;
         4'h9:    p = 7'h6F;
         4'hA:    p = 7'h77;
         4'hB:    p = 7'h7C;
         4'hC:    p = 7'h39;
         4'hD:    p = 7'h5E;
         4'hE:    p = 7'h79;
         default: p = 7'h71;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/updown_count_monitor_seg7_decoder.sv
// Combinational hex nibble to seven-segment decoder with selectable polarity.
module updown_count_monitor_seg7_decoder
   import updown_count_monitor_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0]       nib,
   input  logic             blank,
   output logic [SEG_W-1:0] seg_c
);

   always_comb begin
      seg_c = '0;
      if (!blank) seg_c = seg7_pattern(nib);
      if (ACTIVE_LOW) seg_c = ~seg_c;
   end

endmodule

// File: rtl/updown_count_monitor.sv
// Monitors a free-running up/down counter: classifies each step, flags illegal
// jumps and direction mismatches, counts laps and drives a 7-segment digit.
module updown_count_monitor
   import updown_count_monitor_pkg::*;
#(
   parameter int unsigned CNT_W          = CNT_W_DEFAULT,
   parameter int unsigned LAP_W          = 8,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [CNT_W-1:0]        cnt,
   input  logic                    err_clr,
   output logic [SEG_W-1:0]        seg,
   output logic                    wrap_up,
   output logic                    wrap_dn,
   output logic signed [LAP_W-1:0] laps,
   output logic                    jump_err,
   output logic                    dir_err,
   output logic                    tracking
);

   localparam logic [CNT_W-1:0]        CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
   localparam logic [SEG_W-1:0]        SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic signed [LAP_W-1:0] LAP_MAX   = {1'b0, {(LAP_W-1){1'b1}}};
   localparam logic signed [LAP_W-1:0] LAP_MIN   = {1'b1, {(LAP_W-1){1'b0}}};

   mon_state_t        state;
   logic [CNT_W-1:0]  prev;
   logic              dir_q;
   logic [CNT_W-1:0]  delta_c;
   logic              step_up_c;
   logic              step_dn_c;
   logic              jump_c;
   logic              classify_c;
   logic              wrap_up_c;
   logic              wrap_dn_c;
   logic              blank_c;
   logic [SEG_W-1:0]  seg_c;

   // Step classification against the previous sample, modulo 2**CNT_W
   always_comb begin
      delta_c    = cnt - prev;
      step_up_c  = (delta_c == CNT_ONE);
      step_dn_c  = (delta_c == CNT_MAX);
      jump_c     = (delta_c != '0) && !step_up_c && !step_dn_c;
      classify_c = (state == ST_TRACK) && !err_clr;
      wrap_up_c  = classify_c && step_up_c && (prev == CNT_MAX);
      wrap_dn_c  = classify_c && step_dn_c && (prev == '0);
      blank_c    = (32'(cnt) > 32'd15);
   end

   updown_count_monitor_seg7_decoder #(
      .ACTIVE_LOW (SEG_ACTIVE_LOW)
   ) u_seg7_decoder (
      .nib   (4'(cnt)),
      .blank (blank_c),
      .seg_c (seg_c)
   );

   // Sample history, FSM and sticky flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_INIT;
         prev     <= '0;
         dir_q    <= 1'b0;
         seg      <= SEG_BLANK;
         wrap_up  <= 1'b0;
         wrap_dn  <= 1'b0;
         jump_err <= 1'b0;
         dir_err  <= 1'b0;
         tracking <= 1'b0;
      end else begin
         prev    <= cnt;
         dir_q   <= en;
         seg     <= seg_c;
         wrap_up <= wrap_up_c;
         wrap_dn <= wrap_dn_c;
         if (err_clr) begin
            jump_err <= 1'b0;
            dir_err  <= 1'b0;
            state    <= ST_INIT;
            tracking <= 1'b0;
         end else begin
            case (state)
               ST_INIT: begin
                  state    <= ST_TRACK;
                  tracking <= 1'b1;
               end
               ST_TRACK: begin
                  if (jump_c) begin
                     jump_err <= 1'b1;
                     state    <= ST_ERROR;
                     tracking <= 1'b0;
                  end else if ((step_up_c && !dir_q) || (step_dn_c && dir_q)) begin
                     dir_err <= 1'b1;
                  end
               end
               ST_ERROR: begin
                  state <= ST_ERROR;
               end
               default: begin
                  state    <= ST_INIT;
                  tracking <= 1'b0;
               end
            endcase
         end
      end
   end

   // Saturating signed lap total
   always_ff @(posedge clk) begin
      if (rst) begin
         laps <= '0;
      end else if (wrap_up_c && (laps != LAP_MAX)) begin
         laps <= laps + LAP_W'(1);
      end else if (wrap_dn_c && (laps != LAP_MIN)) begin
         laps <= laps - LAP_W'(1);
      end
   end

endmodule

// File: tb/tb_updown_count_monitor.sv
// Directed bench for updown_count_monitor: vector table plus lap saturation runs
// on a second instance with a 4-bit lap total.
module tb_updown_count_monitor;

   typedef struct {
      logic       rst;
      logic       en;
      logic       clr;
      logic [2:0] cnt;
      int         dig;
      logic       wu;
      logic       wd;
      int         laps;
      logic       je;
      logic       de;
      logic       trk;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic              err_clr = 1'b0;
   logic [2:0]        cnt = 3'd0;

   logic [6:0]        seg8, seg4;
   logic              wu8, wd8, je8, de8, trk8;
   logic              wu4, wd4, je4, de4, trk4;
   logic signed [7:0] laps8;
   logic signed [3:0] laps4;

   int n_tests = 0;
   int n_fail  = 0;
   vec_t vq[$];

   always #5 clk = ~clk;

   updown_count_monitor #(.CNT_W(3), .LAP_W(8), .SEG_ACTIVE_LOW(1'b1)) dut8 (
      .clk(clk), .rst(rst), .en(en), .cnt(cnt), .err_clr(err_clr),
      .seg(seg8), .wrap_up(wu8), .wrap_dn(wd8), .laps(laps8),
      .jump_err(je8), .dir_err(de8), .tracking(trk8)
   );

   updown_count_monitor #(.CNT_W(3), .LAP_W(4), .SEG_ACTIVE_LOW(1'b1)) dut4 (
      .clk(clk), .rst(rst), .en(en), .cnt(cnt), .err_clr(err_clr),
      .seg(seg4), .wrap_up(wu4), .wrap_dn(wd4), .laps(laps4),
      .jump_err(je4), .dir_err(de4), .tracking(trk4)
   );

   // Active-low digit patterns; negative digit means blank
   function automatic logic [6:0] sg(input int d);
      case (d)
         0:       return 7'h40;
         1:       return 7'h79;
         2:       return 7'h24;
         3:       return 7'h30;
         4:       return 7'h19;
         5:       return 7'h12;
         6:       return 7'h02;
         7:       return 7'h78;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic vec_t mk(input logic r, input logic e, input logic c, input int n,
                               input int d, input logic wu, input logic wd, input int l,
                               input logic je, input logic de, input logic t);
      vec_t v;
      v.rst = r; v.en = e; v.clr = c; v.cnt = 3'(n);
      v.dig = d; v.wu = wu; v.wd = wd; v.laps = l;
      v.je = je; v.de = de; v.trk = t;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic c, input int n);
      @(negedge clk);
      rst = r; en = e; err_clr = c; cnt = 3'(n);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset
      vq.push_back(mk(1,0,0,0, -1,0,0,0, 0,0,0));
      vq.push_back(mk(1,0,0,0, -1,0,0,0, 0,0,0));
      vq.push_back(mk(0,1,0,0,  0,0,0,0, 0,0,1));
      // count up through a wrap
      for (int k = 1; k < 8; k++) vq.push_back(mk(0,1,0,k, k,0,0,0, 0,0,1));
      vq.push_back(mk(0,1,0,0,  0,1,0,1, 0,0,1));
      vq.push_back(mk(0,1,0,1,  1,0,0,1, 0,0,1));
      // count down through a wrap
      vq.push_back(mk(0,0,0,2,  2,0,0,1, 0,0,1));
      vq.push_back(mk(0,0,0,1,  1,0,0,1, 0,0,1));
      vq.push_back(mk(0,0,0,0,  0,0,0,1, 0,0,1));
      vq.push_back(mk(0,0,0,7,  7,0,1,0, 0,0,1));
      vq.push_back(mk(0,0,0,6,  6,0,0,0, 0,0,1));
      vq.push_back(mk(0,0,0,5,  5,0,0,0, 0,0,1));
      vq.push_back(mk(0,0,0,4,  4,0,0,0, 0,0,1));
      vq.push_back(mk(0,0,0,3,  3,0,0,0, 0,0,1));
      // jump 3->6, wraps ignored in ERROR, then clear
      vq.push_back(mk(0,0,0,6,  6,0,0,0, 1,0,0));
      vq.push_back(mk(0,1,0,7,  7,0,0,0, 1,0,0));
      vq.push_back(mk(0,1,0,0,  0,0,0,0, 1,0,0));
      vq.push_back(mk(0,1,1,1,  1,0,0,0, 0,0,0));
      vq.push_back(mk(0,1,0,2,  2,0,0,0, 0,0,1));
      // direction mismatch on 4->5, then holds
      vq.push_back(mk(0,1,0,3,  3,0,0,0, 0,0,1));
      vq.push_back(mk(0,0,0,4,  4,0,0,0, 0,0,1));
      vq.push_back(mk(0,1,0,5,  5,0,0,0, 0,1,1));
      vq.push_back(mk(0,1,0,5,  5,0,0,0, 0,1,1));
      vq.push_back(mk(0,1,0,5,  5,0,0,0, 0,1,1));
      vq.push_back(mk(0,1,0,6,  6,0,0,0, 0,1,1));
      vq.push_back(mk(0,1,0,7,  7,0,0,0, 0,1,1));
      // clear on the same edge as a 7->0 wrap: wrap ignored
      vq.push_back(mk(0,1,1,0,  0,0,0,0, 0,0,0));
      vq.push_back(mk(0,1,0,1,  1,0,0,0, 0,0,1));

      foreach (vq[i]) begin
         step(vq[i].rst, vq[i].en, vq[i].clr, int'(vq[i].cnt));
         chk($sformatf("v%0d.seg", i),      32'(seg8),  32'(sg(vq[i].dig)));
         chk($sformatf("v%0d.wrap_up", i),  32'(wu8),   32'(vq[i].wu));
         chk($sformatf("v%0d.wrap_dn", i),  32'(wd8),   32'(vq[i].wd));
         chk($sformatf("v%0d.laps", i),     32'(laps8), 32'(vq[i].laps));
         chk($sformatf("v%0d.laps4", i),    32'(laps4), 32'(vq[i].laps));
         chk($sformatf("v%0d.jump_err", i), 32'(je8),   32'(vq[i].je));
         chk($sformatf("v%0d.dir_err", i),  32'(de8),   32'(vq[i].de));
         chk($sformatf("v%0d.tracking", i), 32'(trk8),  32'(vq[i].trk));
      end

      // positive saturation with a 4-bit lap total
      step(1,1,0,0);
      chk("sat.rst_laps4", 32'(laps4), 32'(0));
      step(0,1,0,0);
      for (int w = 1; w <= 9; w++) begin
         for (int k = 1; k < 8; k++) step(0,1,0,k);
         chk($sformatf("sat%0d.pre_wrap_up", w), 32'(wu4), 32'(0));
         step(0,1,0,0);
         chk($sformatf("sat%0d.wrap_up", w), 32'(wu4),   32'(1));
         chk($sformatf("sat%0d.laps4", w),   32'(laps4), 32'((w > 7) ? 7 : w));
         chk($sformatf("sat%0d.laps8", w),   32'(laps8), 32'(w));
      end
      step(0,1,1,0);
      chk("sat.clr_laps4", 32'(laps4), 32'(7));
      chk("sat.clr_laps8", 32'(laps8), 32'(9));
      chk("sat.clr_trk",   32'(trk4),  32'(0));
      step(1,1,0,0);
      chk("sat.rst_mid_laps4", 32'(laps4), 32'(0));
      chk("sat.rst_mid_laps8", 32'(laps8), 32'(0));

      // negative saturation
      step(0,0,0,0);
      for (int w = 1; w <= 9; w++) begin
         step(0,0,0,7);
         chk($sformatf("nsat%0d.wrap_dn", w), 32'(wd4),   32'(1));
         chk($sformatf("nsat%0d.wrap_up", w), 32'(wu4),   32'(0));
         chk($sformatf("nsat%0d.laps4", w),   32'(laps4), 32'((w > 8) ? -8 : -w));
         chk($sformatf("nsat%0d.laps8", w),   32'(laps8), 32'(-w));
         for (int k = 6; k >= 0; k--) step(0,0,0,k);
      end
      chk("nsat.dir_err", 32'(de4), 32'(0));
      chk("nsat.jump_err", 32'(je4), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
